// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction-field helpers for acc_cpu.
package acc_cpu_pkg;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_SKZ = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LDA = 4'h5;
  localparam logic [3:0] OP_STO = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_SUB = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_SKC = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  // Widest instruction word the field helpers accept.
  localparam int unsigned IR_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_HALT
  } state_t;

  // Opcode sits in the top four bits of a data_w-wide instruction word.
  function automatic logic [3:0] ir_opcode(input logic [IR_MAX_W-1:0] ir,
                                           input int unsigned data_w);
    logic [IR_MAX_W-1:0] shifted;
    shifted = ir >> (data_w - 4);
    return shifted[3:0];
  endfunction

  // Operand address occupies the low addr_w bits; caller truncates.
  function automatic logic [IR_MAX_W-1:0] ir_operand(input logic [IR_MAX_W-1:0] ir,
                                                     input int unsigned addr_w);
    return ir & ((IR_MAX_W'(1) << addr_w) - IR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: memory-operand ops plus the two shifts.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic              cin,
  output logic [DATA_W-1:0] res,
  output logic              cout
);

  logic [DATA_W:0] sum;

  // Result and carry select; carry passes through for logic ops.
  always_comb begin
    res  = a;
    cout = cin;
    sum  = '0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, d};
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      OP_ADC: begin
        sum  = {1'b0, a} + {1'b0, d} + (DATA_W+1)'(cin);
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      OP_SUB: begin
        res  = a - d;
        cout = (a >= d);
      end
      OP_AND: res = a & d;
      OP_OR:  res = a | d;
      OP_XOR: res = a ^ d;
      OP_LDA: res = d;
      OP_SHL: begin
        res  = {a[DATA_W-2:0], 1'b0};
        cout = a[DATA_W-1];
      end
      OP_SHR: begin
        res  = {1'b0, a[DATA_W-1:1]};
        cout = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_cpu.sv
// Multi-cycle accumulator CPU with a single handshaked memory port.
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              fetch,
  output logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic [3:0]        opcode
);

  if (DATA_W < ADDR_W + 4 || DATA_W > IR_MAX_W) begin : g_width_check
    $error("acc_cpu: DATA_W must be >= ADDR_W + 4 and <= 64");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, operand;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d, alu_res;
  logic              carry_q, carry_d, alu_cout;
  logic [3:0]        op;

  assign op      = ir_opcode(IR_MAX_W'(ir_q), DATA_W);
  assign operand = ADDR_W'(ir_operand(IR_MAX_W'(ir_q), ADDR_W));

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (op),
    .a    (acc_q),
    .d    (mem_rdata),
    .cin  (carry_q),
    .res  (alu_res),
    .cout (alu_cout)
  );

  // State, PC, IR, accumulator and carry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  // Next-state, execute and bus outputs. Requests are gated by reset so
  // mem_req/fetch drop the instant reset asserts, even though the state
  // register already holds FETCH.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    fetch    = 1'b0;
    halt     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = reset;
        fetch   = reset;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        case (op)
          OP_HLT: state_d = ST_HALT;
          OP_SKZ: if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
          OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_SUB, OP_OR, OP_ADC:
            state_d = ST_MEM_RD;
          OP_STO: state_d = ST_MEM_WR;
          OP_JMP: pc_d = operand;
          OP_SKC: if (carry_q) pc_d = pc_q + ADDR_W'(1);
          OP_SHL, OP_SHR: begin
            acc_d   = alu_res;
            carry_d = alu_cout;
          end
          OP_LDI: acc_d = DATA_W'(operand);
          default: ;
        endcase
      end
      ST_MEM_RD: begin
        mem_req  = reset;
        mem_addr = operand;
        if (mem_ack) begin
          acc_d   = alu_res;
          carry_d = alu_cout;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        mem_req  = reset;
        mem_we   = reset;
        mem_addr = operand;
        if (mem_ack) state_d = ST_FETCH;
      end
      ST_HALT: begin
        halt = 1'b1;
        if (resume) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign mem_wdata = acc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign opcode    = op;

endmodule

// File: tb/tb_acc_cpu.sv
// Self-checking bench for acc_cpu: directed programs plus random programs
// compared against an instruction-level interpreter.
module tb_acc_cpu;

  localparam int unsigned       DW  = 16;
  localparam int unsigned       AW  = 12;
  localparam logic [AW-1:0]     RPC = 12'h000;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          resume = 1'b0;
  logic          mem_req, mem_we, mem_ack, fetch, halt, carry;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, acc;
  logic [3:0]    opcode;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  acc_cpu #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .resume    (resume),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .fetch     (fetch),
    .halt      (halt),
    .pc        (pc),
    .acc       (acc),
    .carry     (carry),
    .opcode    (opcode)
  );

  always #5 clk = ~clk;

  // Bus-side memory with a programmable number of wait cycles per access.
  logic [DW-1:0] mem [0:4095];
  int unsigned   waits   = 0;
  int unsigned   wcnt    = 0;
  logic          clr     = 1'b0;
  logic          ld_en   = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  assign mem_ack   = mem_req && (wcnt == waits);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!reset || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
  end

  // Reference machine state.
  logic [DW-1:0] mm [0:4095];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  logic          m_carry;
  logic [AW-1:0] mq[$];
  logic [AW-1:0] fq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ins(input logic [3:0] op, input logic [AW-1:0] a);
    return {op, a};
  endfunction

  // Instruction-level interpreter: runs from m_pc until HLT, returns cycles.
  function automatic int unsigned model_run(input int unsigned w);
    int unsigned   cyc = 0;
    logic [DW-1:0] ir, d;
    logic [3:0]    op;
    logic [AW-1:0] a;
    logic [DW:0]   t;
    for (int n = 0; n < 4096; n++) begin
      mq.push_back(m_pc);
      ir   = mm[m_pc];
      m_pc = m_pc + 12'd1;
      cyc += 2 + w;
      op   = ir[15:12];
      a    = ir[11:0];
      d    = mm[a];
      if (op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA}) cyc += 1 + w;
      case (op)
        4'h0: return cyc;
        4'h1: if (m_acc == 0) m_pc = m_pc + 12'd1;
        4'h2: begin t = {1'b0, m_acc} + {1'b0, d}; m_acc = t[15:0]; m_carry = t[16]; end
        4'h3: m_acc = m_acc & d;
        4'h4: m_acc = m_acc ^ d;
        4'h5: m_acc = d;
        4'h6: mm[a] = m_acc;
        4'h7: m_pc = a;
        4'h8: begin m_carry = (m_acc >= d); m_acc = m_acc - d; end
        4'h9: m_acc = m_acc | d;
        4'hA: begin t = {1'b0, m_acc} + {1'b0, d} + {16'd0, m_carry}; m_acc = t[15:0]; m_carry = t[16]; end
        4'hB: if (m_carry) m_pc = m_pc + 12'd1;
        4'hC: begin m_carry = m_acc[15]; m_acc = m_acc << 1; end
        4'hD: begin m_carry = m_acc[0]; m_acc = m_acc >> 1; end
        4'hE: m_acc = {4'b0, a};
        default: ;
      endcase
    end
    return cyc;
  endfunction

  task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mm[a]   = d;
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic begin_test(input int unsigned w);
    @(negedge clk);
    reset  = 1'b0;
    resume = 1'b0;
    waits  = w;
    clr    = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4096; i++) mm[i] = '0;
    m_pc    = RPC;
    m_acc   = '0;
    m_carry = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_req",   32'(mem_req), 32'd1);
    check("rel_fetch", 32'(fetch), 32'd1);
    check("rel_addr",  32'(mem_addr), 32'(RPC));
  endtask

  task automatic run_to_halt(input int unsigned limit, input int unsigned resume_at,
                             output int unsigned cyc);
    logic          p_req, p_ack, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    cyc = 0;
    fq.delete();
    while (!halt && cyc < limit) begin
      if (fetch && mem_ack) fq.push_back(mem_addr);
      p_req  = mem_req;
      p_ack  = mem_ack;
      p_we   = mem_we;
      p_addr = mem_addr;
      p_wd   = mem_wdata;
      if (resume_at != 0 && cyc == resume_at) resume = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      resume = 1'b0;
      if (p_req && !p_ack) begin
        check("hs_req",   32'(mem_req), 32'd1);
        check("hs_addr",  32'(mem_addr), 32'(p_addr));
        check("hs_we",    32'(mem_we), 32'(p_we));
        check("hs_wdata", 32'(mem_wdata), 32'(p_wd));
      end
    end
    check("halt_seen", 32'(halt), 32'd1);
  endtask

  task automatic exec(input string tag, input int unsigned resume_at, output int unsigned dc);
    int unsigned mc;
    mq.delete();
    mc = model_run(waits);
    run_to_halt(mc + 40, resume_at, dc);
    check({tag, "_cycles"}, dc, mc);
    check({tag, "_acc"},    32'(acc), 32'(m_acc));
    check({tag, "_carry"},  32'(carry), 32'(m_carry));
    check({tag, "_pc"},     32'(pc), 32'(m_pc));
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_nfetch"}, fq.size(), mq.size());
    for (int i = 0; i < fq.size() && i < mq.size(); i++)
      check({tag, "_faddr"}, 32'(fq[i]), 32'(mq[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned   dc, n;
    logic [3:0]    op;
    logic [AW-1:0] opr;

    #2 reset = 1'b0;
    #1;
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_fetch", 32'(fetch), 32'd0);
    check("rst_halt",  32'(halt), 32'd0);
    check("rst_pc",    32'(pc), 32'(RPC));
    check("rst_acc",   32'(acc), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_op",    32'(opcode), 32'd0);

    // LDA/ADD/STO/HLT with zero-wait and 3-wait memory, then resume.
    for (int pass = 0; pass < 2; pass++) begin
      begin_test(pass == 0 ? 0 : 3);
      put(12'h000, ins(4'h5, 12'h010));
      put(12'h001, ins(4'h2, 12'h011));
      put(12'h002, ins(4'h6, 12'h012));
      put(12'h003, ins(4'h0, 12'h000));
      put(12'h010, 16'h1234);
      put(12'h011, 16'h0001);
      go();
      exec("t1", 1, dc);
      check("t1_lat", dc, pass == 0 ? 32'd11 : 32'd32);
      check("t1_mem", 32'(mem[12'h012]), 32'h1235);
      check("t1_pc",  32'(pc), 32'h004);
      put(12'h004, ins(4'hE, 12'h055));
      put(12'h005, ins(4'h0, 12'h000));
      check("t1_still_halt", 32'(halt), 32'd1);
      resume = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resume = 1'b0;
      check("res_fetch", 32'(fetch), 32'd1);
      check("res_addr",  32'(mem_addr), 32'h004);
      check("res_halt",  32'(halt), 32'd0);
      exec("t1r", 0, dc);
      check("t1r_acc", 32'(acc), 32'h0055);
    end

    // Carry out of ADD, SKZ skipping a JMP, then ADC with carry-in.
    begin_test(1);
    put(12'h000, ins(4'h5, 12'h010));
    put(12'h001, ins(4'h2, 12'h011));
    put(12'h002, ins(4'h1, 12'h000));
    put(12'h003, ins(4'h7, 12'h000));
    put(12'h004, ins(4'hA, 12'h012));
    put(12'h005, ins(4'h0, 12'h000));
    put(12'h010, 16'hFFFF);
    put(12'h011, 16'h0001);
    go();
    exec("t2", 2, dc);
    check("t2_acc",   32'(acc), 32'h0001);
    check("t2_carry", 32'(carry), 32'd0);
    check("t2_pc",    32'(pc), 32'h006);

    // Subtraction borrow in both directions.
    begin_test(0);
    put(12'h000, ins(4'h5, 12'h010));
    put(12'h001, ins(4'h8, 12'h011));
    put(12'h002, ins(4'h6, 12'h020));
    put(12'h003, ins(4'hB, 12'h000));
    put(12'h004, ins(4'h5, 12'h011));
    put(12'h005, ins(4'h8, 12'h010));
    put(12'h006, ins(4'h0, 12'h000));
    put(12'h010, 16'h0005);
    put(12'h011, 16'h0007);
    go();
    exec("t3", 3, dc);
    check("t3_mem",   32'(mem[12'h020]), 32'hFFFE);
    check("t3_acc",   32'(acc), 32'h0002);
    check("t3_carry", 32'(carry), 32'd1);

    // PC wrap through SKZ at the top of memory, then JMP.
    begin_test(0);
    put(12'h000, ins(4'h7, 12'hFFF));
    put(12'hFFF, ins(4'h1, 12'h000));
    put(12'h001, ins(4'h7, 12'hABC));
    put(12'hABC, ins(4'h0, 12'h000));
    go();
    exec("t4", 0, dc);
    check("t4_pc", 32'(pc), 32'hABD);
    check("t4_f1", fq.size() > 1 ? 32'(fq[1]) : 32'hDEAD, 32'hFFF);
    check("t4_f2", fq.size() > 2 ? 32'(fq[2]) : 32'hDEAD, 32'h001);
    check("t4_f3", fq.size() > 3 ? 32'(fq[3]) : 32'hDEAD, 32'hABC);

    // Reset while a memory read is waiting for ack.
    begin_test(5);
    put(12'h000, ins(4'hE, 12'h055));
    put(12'h001, ins(4'h5, 12'h010));
    put(12'h002, ins(4'h0, 12'h000));
    put(12'h010, 16'h1234);
    go();
    n = 0;
    while (!(mem_req && !fetch) && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("t5_in_rd",  32'(mem_req && !fetch), 32'd1);
    check("t5_acc_pre", 32'(acc), 32'h0055);
    #1 reset = 1'b0;
    #1;
    check("t5_req_drop", 32'(mem_req), 32'd0);
    check("t5_acc_rst",  32'(acc), 32'd0);
    check("t5_pc_rst",   32'(pc), 32'(RPC));
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t5_acc_hold", 32'(acc), 32'd0);
    reset = 1'b1;
    #1;
    check("t5_rel_req",  32'(mem_req), 32'd1);
    check("t5_rel_addr", 32'(mem_addr), 32'(RPC));
    exec("t5", 4, dc);
    check("t5_acc", 32'(acc), 32'h1234);

    // Random programs: forward-only control flow, two trailing HLTs.
    for (int it = 0; it < 10; it++) begin
      begin_test($urandom_range(0, 2));
      for (int a = 0; a < 16; a++)
        put(12'h800 + 12'(a), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      for (int i = 0; i < 12; i++) begin
        op = 4'($urandom_range(1, 15));
        if (op == 4'h7) opr = 12'(i + 2);
        else if (op == 4'hE) opr = 12'($urandom);
        else opr = 12'h800 + 12'($urandom_range(0, 15));
        put(12'(i), ins(op, opr));
      end
      put(12'd12, ins(4'h0, 12'h000));
      put(12'd13, ins(4'h0, 12'h000));
      go();
      exec("rnd", $urandom_range(1, 6), dc);
      for (int a = 0; a < 16; a++)
        check("rnd_mem", 32'(mem[12'h800 + 12'(a)]), 32'(mm[12'h800 + 12'(a)]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_cpu.md
# acc_cpu

Parametrised multi-cycle accumulator CPU core, the next generation of the team's 16-bit accumulator CPU. It replaces the fixed 8-phase clock generator with a handshaked single memory port that tolerates wait states. It widens the instruction set to 16 opcodes with a carry flag, and adds halt/resume. It sits between the system memory/bus fabric and the debug/monitor logic.

## Interface
Parameters:
- DATA_W, 16, accumulator/memory word width; must satisfy DATA_W >= ADDR_W+4 (elaboration error otherwise)
- ADDR_W, 12, address width; PC and operand field width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- resume  in  1  one-cycle pulse, leaves HALT
- mem_req  out  1  access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data (accumulator)
- mem_rdata  in  DATA_W  read data, sampled when mem_ack=1
- mem_ack  in  1  access complete this cycle
- fetch  out  1  high while in FETCH
- halt  out  1  high while in HALT
- pc  out  ADDR_W  program counter
- acc  out  DATA_W  accumulator
- carry  out  1  carry flag
- opcode  out  4  current instruction opcode

## Operation
- Instruction word: opcode = mem_rdata[DATA_W-1 -: 4]; operand address = mem_rdata[ADDR_W-1:0]; bits between them are ignored.
- States: FETCH, DECODE, MEM_RD, MEM_WR, HALT.
- FETCH: req=1, we=0, addr=pc. On ack, IR captured and pc<=pc+1 (mod 2^ADDR_W). Next state is DECODE.
- DECODE executes or dispatches by opcode:
  - 0 HLT: go to HALT.
  - 1 SKZ: if acc==0, pc<=pc+1.
  - 2 ADD, 3 AND, 4 XOR, 5 LDA, 8 SUB, 9 OR, A ADC: go to MEM_RD.
  - 6 STO: go to MEM_WR.
  - 7 JMP: pc<=operand.
  - B SKC: if carry, pc<=pc+1.
  - C SHL: acc<<1, carry<=old msb.
  - D SHR: logical acc>>1, carry<=old lsb.
  - E LDI: acc<=zero-extended operand.
  - F NOP.
  - Non-memory opcodes return to FETCH.
- MEM_RD: req=1, we=0, addr=operand. On ack, acc<=ALU(acc, rdata), then FETCH. The ALU ops are:
  - ADD: {carry,acc}<=acc+d.
  - ADC: {carry,acc}<=acc+d+carry.
  - SUB: acc<=acc-d, carry<=(acc>=d unsigned), where carry means no-borrow.
  - AND/OR/XOR/LDA: carry unchanged.
- MEM_WR: req=1, we=1, addr=operand, wdata=acc. On ack, go to FETCH.
- HALT: no requests; halt=1. resume=1 goes to FETCH at the current pc, which already points past the HLT. resume is ignored in all other states.
- Handshake: addr/we/wdata stay stable while req=1 and ack=0. ack while req=0 is ignored. req deasserts in the cycle after the ack edge unless the next state also requests.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, acc=0, carry=0, IR=0 (opcode=0), halt=0. mem_req=1 and fetch=1 from the first cycle after reset deasserts. Outputs change asynchronously on reset assertion, and mem_req drops immediately.
- With a zero-wait memory (ack in the same cycle as req), instructions take:
  - FETCH: 1 cycle.
  - DECODE: 1 cycle.
  - Memory op: 1 cycle.
  - Total: non-memory instructions 2 cycles; LDA/ADD/.../STO 3 cycles.
- Each wait cycle (req=1, ack=0) adds exactly one cycle.
- acc/carry/pc are updated on the edge that ends the executing state and are visible in the next cycle.
- halt rises the cycle after DECODE of HLT. The first FETCH request follows in the cycle after the resume edge.
- pc wraps from 2^ADDR_W-1 to 0, including on SKZ/SKC double-increment.
- Reset during a pending access abandons it; no partial acc update.

## Structure
- Package acc_cpu_pkg: opcode localparams (OP_HLT..OP_NOP), state encoding enum, instruction-field helper functions parametrised by widths.
- Sub-module acc_cpu_alu: combinational; inputs are op, acc, d, and carry-in; outputs are result and carry-out. Covers both memory ALU ops and SHL/SHR.
- Top holds the FSM, PC, IR, accumulator and carry registers.

## Test plan
- Reset release, zero-wait memory, program LDA 0x010 (mem=0x1234); ADD 0x011 (0x0001); STO 0x012; HLT -> mem[0x012]=0x1235. halt rises after 3+3+3+2 = 11 cycles. pc=0x004.
- ADD with acc=0xFFFF, d=0x0001 -> acc=0x0000, carry=1. Next SKZ skips the following JMP. Then ADC d=0 -> acc=0x0001, carry=0.
- SUB 5-7 -> acc=0xFFFE, carry=0. SUB 7-5 -> acc=0x0002, carry=1.
- Memory inserts 3 wait cycles on every ack -> addr/we/wdata stable throughout, instruction latency +3 per access, results identical to the zero-wait run.
- pc=0xFFF holding SKZ with acc=0 -> pc=0x001. JMP 0xABC -> next fetch address 0xABC.
- Reset asserted mid-MEM_RD with ack pending -> mem_req drops immediately, acc=0. After release, fetch at RESET_PC. resume pulses outside HALT have no effect.
